// File: rtl/memory_access_stage.sv
// MEM stage of the RV32I pipeline: byte/half/word loads and stores over a req/ready bus,
// with upstream stall, hung-access timeout and the MEM/WB pipeline register.
module memory_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_write_m,
  input  logic        reg_write_m,
  input  logic [1:0]  result_src_m,
  input  logic [2:0]  funct3_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic [31:0] pc_plus_4_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_m,
  output logic        reg_write_w,
  output logic [4:0]  rd_w,
  output logic [31:0] result_w,
  output logic        misalign_w,
  output logic        bus_fault_w
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic [1:0]  lane;
  logic        mem_op, illegal, abort;
  logic        is_half, is_word, bad_load_fn;
  logic [31:0] shifted, load_data, sel_result;

  assign lane      = alu_result_m[1:0];
  assign mem_op    = mem_write_m | (result_src_m == 2'b01);
  assign is_half   = (funct3_m[1:0] == 2'b01);
  assign is_word   = (funct3_m[1:0] == 2'b10);
  assign bad_load_fn = !mem_write_m &&
                       ((funct3_m == 3'b011) || (funct3_m[2:1] == 2'b11));
  assign illegal   = (is_half && lane[0]) || (is_word && (lane != 2'b00)) || bad_load_fn;

  // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dmem_req   = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op && !illegal) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            state_next = S_WAIT;
            cnt_next   = 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == TIMEOUT_CNT) begin
          // Abort cycle: request withdrawn and any late ready is ignored.
          abort      = 1'b1;
          state_next = S_IDLE;
          cnt_next   = 8'd0;
        end else begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            state_next = S_IDLE;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = cnt + 8'd1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 8'd0;
      end
    endcase
    // The bus must see no request while reset is asserted, even with live inputs.
    if (!rst_n) begin
      dmem_req = 1'b0;
      abort    = 1'b0;
    end
  end

  assign stall_m   = dmem_req & !dmem_ready;
  assign dmem_we   = mem_write_m;
  assign dmem_addr = {alu_result_m[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = write_data_m;
    if (mem_write_m) begin
      case (funct3_m[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << lane;
          dmem_wdata = {4{write_data_m[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << lane;
          dmem_wdata = {2{write_data_m[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = write_data_m;
        end
      endcase
    end
  end

  assign shifted = dmem_rdata >> {lane, 3'b000};

  always_comb begin
    case (funct3_m)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    case (result_src_m)
      2'b01:   sel_result = load_data;
      2'b10:   sel_result = pc_plus_4_m;
      default: sel_result = alu_result_m;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_w <= 1'b0;
      rd_w        <= 5'd0;
      result_w    <= 32'd0;
      misalign_w  <= 1'b0;
      bus_fault_w <= 1'b0;
    end else begin
      reg_write_w <= 1'b0;
      rd_w        <= 5'd0;
      result_w    <= 32'd0;
      misalign_w  <= 1'b0;
      bus_fault_w <= 1'b0;
      if (stall_m) begin
        // Bubble: nothing retires while the bus is busy.
      end else if (abort) begin
        bus_fault_w <= 1'b1;
      end else if (mem_op && illegal) begin
        misalign_w <= 1'b1;
      end else begin
        reg_write_w <= reg_write_m;
        rd_w        <= rd_m;
        result_w    <= sel_result;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed spec cases plus random accesses
// compared against a byte-level reference model.
module tb_memory_access_stage;

  localparam int TIMEOUT_P = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_write_m, reg_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus_4_m;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_m, reg_write_w, misalign_w, bus_fault_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;

  int n_checks = 0;
  int n_fail   = 0;

  memory_access_stage #(.TIMEOUT(TIMEOUT_P)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_write_m(mem_write_m), .reg_write_m(reg_write_m), .result_src_m(result_src_m),
    .funct3_m(funct3_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .pc_plus_4_m(pc_plus_4_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_m(stall_m), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .misalign_w(misalign_w), .bus_fault_w(bus_fault_w)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
    return (addr % access_size(f3)) == 0;
  endfunction

  // Loaded value built byte by byte from the addressed bytes of the read word.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int size, base;
    logic [31:0] v;
    logic [7:0] bytes [4];
    for (int i = 0; i < 4; i++) bytes[i] = word[8*i +: 8];
    size = access_size(f3);
    base = int'(addr % 4);
    if (size == 4) return word;
    v = 32'd0;
    for (int i = 0; i < size; i++) v = v | (32'(bytes[base + i]) << (8 * i));
    if (f3[2] == 1'b0 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [2:0] f3,
                                          input logic [31:0] addr);
    logic [3:0] be;
    int base, size;
    if (!we) return 4'hF;
    base = int'(addr % 4);
    size = access_size(f3);
    be = 4'h0;
    for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + size);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    int size;
    size = access_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % size) +: 8];
    return w;
  endfunction

  task automatic set_nop();
    mem_write_m  = 1'b0;
    reg_write_m  = 1'b0;
    result_src_m = 2'b00;
    funct3_m     = 3'b000;
    rd_m         = 5'd0;
    alu_result_m = 32'd0;
    write_data_m = 32'd0;
    pc_plus_4_m  = 32'd0;
    dmem_ready   = 1'b0;
    dmem_rdata   = 32'd0;
  endtask

  // One instruction through MEM. wait_n = cycles before ready (-1: never ready).
  task automatic access(input logic we, input logic rw, input logic [1:0] rs,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                        input logic [31:0] wd, input int wait_n, input logic [31:0] rdata);
    bit memop, legal, fin, exp_req, exp_stall;
    logic [31:0] pc4, exp_res;
    int k;
    @(negedge clk);
    pc4 = $urandom;
    mem_write_m = we; reg_write_m = rw; result_src_m = rs; funct3_m = f3; rd_m = rd;
    alu_result_m = addr; write_data_m = wd; pc_plus_4_m = pc4;
    memop = we || (rs == 2'b01);
    legal = is_legal(we, f3, addr);
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      dmem_ready = memop && legal && (k == wait_n);
      dmem_rdata = dmem_ready ? rdata : $urandom;
      #1;
      exp_req   = memop && legal && (k < TIMEOUT_P);
      exp_stall = exp_req && !dmem_ready;
      check("dmem_req", 32'(dmem_req), 32'(exp_req));
      check("stall_m", 32'(stall_m), 32'(exp_stall));
      if (exp_req && k == 0) begin
        check("dmem_we", 32'(dmem_we), 32'(we));
        check("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check("dmem_be", 32'(dmem_be), 32'(model_be(we, f3, addr)));
        if (we) check("dmem_wdata", dmem_wdata, model_wdata(f3, wd));
      end
      @(posedge clk);
      #1;
      if (exp_stall) begin
        check("bubble_reg_write", 32'(reg_write_w), 32'd0);
        check("bubble_fault", 32'({misalign_w, bus_fault_w}), 32'd0);
        k++;
        @(negedge clk);
      end else begin
        fin = 1'b1;
      end
    end
    if (memop && !legal) begin
      check("illegal_reg_write", 32'(reg_write_w), 32'd0);
      check("misalign_w", 32'(misalign_w), 32'd1);
      check("illegal_bus_fault", 32'(bus_fault_w), 32'd0);
    end else if (memop && k == TIMEOUT_P) begin
      check("abort_reg_write", 32'(reg_write_w), 32'd0);
      check("bus_fault_w", 32'(bus_fault_w), 32'd1);
      check("abort_misalign", 32'(misalign_w), 32'd0);
    end else begin
      if (rs == 2'b01)      exp_res = model_load(f3, addr, rdata);
      else if (rs == 2'b10) exp_res = pc4;
      else                  exp_res = addr;
      check("reg_write_w", 32'(reg_write_w), 32'(rw));
      check("pulses_clear", 32'({misalign_w, bus_fault_w}), 32'd0);
      if (rw) begin
        check("rd_w", 32'(rd_w), 32'(rd));
        check("result_w", result_w, exp_res);
      end
    end
  endtask

  initial begin
    logic [2:0] load_fns [8];
    logic [2:0] f3;
    logic [31:0] addr;
    int kind, wn;
    load_fns = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    rst_n = 1'b0;
    set_nop();
    result_src_m = 2'b01;
    funct3_m = 3'b010;
    alu_result_m = 32'h100;
    #12;
    check("reset_req", 32'(dmem_req), 32'd0);
    check("reset_regs", {reg_write_w, rd_w, misalign_w, bus_fault_w, 24'd0}, 32'd0);
    check("reset_result", result_w, 32'd0);
    set_nop();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    access(1'b0, 1'b1, 2'b01, 3'b010, 5'd5, 32'h100, 32'd0, 0, 32'hDEADBEEF);
    access(1'b0, 1'b1, 2'b01, 3'b000, 5'd6, 32'h103, 32'd0, 0, 32'h80112233);
    access(1'b0, 1'b1, 2'b01, 3'b100, 5'd7, 32'h103, 32'd0, 0, 32'h80112233);
    access(1'b0, 1'b1, 2'b01, 3'b001, 5'd8, 32'h102, 32'd0, 0, 32'h80112233);
    access(1'b1, 1'b0, 2'b00, 3'b001, 5'd0, 32'h102, 32'h1234ABCD, 0, 32'd0);
    access(1'b0, 1'b1, 2'b01, 3'b010, 5'd9, 32'h200, 32'd0, 3, 32'hCAFEF00D);
    access(1'b0, 1'b1, 2'b01, 3'b010, 5'd10, 32'h300, 32'd0, -1, 32'd0);
    access(1'b0, 1'b1, 2'b01, 3'b010, 5'd11, 32'h300, 32'd0, TIMEOUT_P, 32'h1);
    access(1'b0, 1'b1, 2'b01, 3'b010, 5'd12, 32'h102, 32'd0, 0, 32'h5);
    access(1'b0, 1'b1, 2'b10, 3'b000, 5'd13, 32'h44, 32'd0, 0, 32'd0);
    access(1'b0, 1'b1, 2'b00, 3'b000, 5'd14, 32'h12345678, 32'd0, 0, 32'd0);
    access(1'b0, 1'b1, 2'b01, 3'b011, 5'd15, 32'h100, 32'd0, 0, 32'd0);

    // Reset in the middle of a waiting access.
    @(negedge clk);
    set_nop();
    reg_write_m = 1'b1; result_src_m = 2'b01; funct3_m = 3'b010; alu_result_m = 32'h400;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("wait_req_before_reset", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_wait_req", 32'(dmem_req), 32'd0);
    check("reset_mid_wait_stall", 32'(stall_m), 32'd0);
    check("reset_mid_wait_regs", {reg_write_w, rd_w, misalign_w, bus_fault_w, 24'd0}, 32'd0);
    set_nop();
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b1, 2'b01, 3'b010, 5'd3, 32'h100, 32'd0, 0, 32'h0BADF00D);

    // Random instruction mix.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      addr = $urandom;
      wn = $urandom_range(0, 5);
      if (wn == 5) wn = -1;
      if (kind <= 1) begin
        access(1'b0, 1'($urandom), 2'($urandom_range(0, 3) == 1 ? 0 : 2), 3'($urandom),
               5'($urandom), addr, 32'($urandom), 0, 32'd0);
      end else if (kind <= 5) begin
        f3 = load_fns[$urandom_range(0, 7)];
        if ($urandom_range(0, 1) == 1) addr = addr & ~32'(access_size(f3) - 1);
        access(1'b0, 1'b1, 2'b01, f3, 5'($urandom), addr, 32'd0, wn, 32'($urandom));
      end else begin
        f3 = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 1) == 1) addr = addr & ~32'(access_size(f3) - 1);
        access(1'b1, 1'b0, 2'b00, f3, 5'd0, addr, 32'($urandom), wn, 32'd0);
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
